// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX hazard inputs and PC/pipeline-register control outputs
// slave = hazard_ctrl, master = pipeline side driving ID/EX info and consuming requests
interface hazard_ctrl_if;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic        id_rs1_used_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs2_used_i;
  logic        id_is_branch_i;
  logic        ex_valid_i;
  logic        ex_mem_read_i;
  logic [4:0]  ex_rd_i;
  logic [1:0]  pipeline_stop_o;
  logic [1:0]  pipeline_stop_branch_o;
  logic        ifid_hold_o;
  logic        idex_bubble_o;
  logic        ifid_flush_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i,
    input  id_is_branch_i, ex_valid_i, ex_mem_read_i, ex_rd_i,
    output pipeline_stop_o, pipeline_stop_branch_o, ifid_hold_o, idex_bubble_o,
    output ifid_flush_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output id_valid_i, id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i,
    output id_is_branch_i, ex_valid_i, ex_mem_read_i, ex_rd_i,
    input  pipeline_stop_o, pipeline_stop_branch_o, ifid_hold_o, idex_bubble_o,
    input  ifid_flush_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch hazard stall sequencer; HAZARD_STATS_EN adds stall/flush counters
// IDLE answers combinationally so the PC reacts at the same edge; LOAD/BRANCH count down the rest.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_STALL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 3) begin : g_bad_load
    $error("LOAD_STALL_CYCLES must be 1..3");
  end
  if (BRANCH_STALL_CYCLES < 1 || BRANCH_STALL_CYCLES > 3) begin : g_bad_branch
    $error("BRANCH_STALL_CYCLES must be 1..3");
  end

  localparam logic [1:0] LOAD_N   = LOAD_STALL_CYCLES[1:0];
  localparam logic [1:0] BRANCH_M = BRANCH_STALL_CYCLES[1:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_BRANCH = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_stop;
  logic [1:0] w_stop_branch;
  logic       w_rs1_hit;
  logic       w_rs2_hit;
  logic       w_load_use;
  logic       w_branch;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_rs1_hit  = bus.id_rs1_used_i && (bus.id_rs1_i == bus.ex_rd_i);
  assign w_rs2_hit  = bus.id_rs2_used_i && (bus.id_rs2_i == bus.ex_rd_i);
  assign w_load_use = bus.id_valid_i && bus.ex_valid_i && bus.ex_mem_read_i &&
                      (bus.ex_rd_i != 5'd0) && (w_rs1_hit || w_rs2_hit);
  assign w_branch   = bus.id_valid_i && bus.id_is_branch_i && !w_load_use;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stop        = 2'd0;
    w_stop_branch = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (w_load_use) begin
          w_stop = LOAD_N;
          if (LOAD_N > 2'd1) begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = LOAD_N - 2'd1;
          end
        end else if (w_branch) begin
          w_stop_branch = BRANCH_M;
          if (BRANCH_M > 2'd1) begin
            w_state_nxt = S_BRANCH;
            w_cnt_nxt   = BRANCH_M - 2'd1;
          end
        end
      end
      S_LOAD: begin
        w_stop    = r_cnt;
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_state_nxt = S_IDLE;
      end
      S_BRANCH: begin
        // ID holds dirty fetches here, so detection is not consulted
        w_stop_branch = r_cnt;
        w_cnt_nxt     = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  assign bus.pipeline_stop_o        = rst_n ? w_stop : 2'd0;
  assign bus.pipeline_stop_branch_o = rst_n ? w_stop_branch : 2'd0;
  assign bus.ifid_hold_o            = (bus.pipeline_stop_o != 2'd0);
  assign bus.idex_bubble_o          = (bus.pipeline_stop_o != 2'd0);
  assign bus.ifid_flush_o           = (bus.pipeline_stop_branch_o != 2'd0);

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (bus.pipeline_stop_o != 2'd0)        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.pipeline_stop_branch_o != 2'd0) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
`else
  assign bus.stall_cnt_o = 32'd0;
  assign bus.flush_cnt_o = 32'd0;
`endif

endmodule
